// File: rtl/ras_pkg.sv
// ras_pkg: shared types and sizing for the return-address-stack sequencer.
//   ras_ctrl_state_t : IDLE (no window), SPEC (window open), CLOSE (close issue)
//   RAS_WIDTH/RAS_DEPTH/RAS_ADDR : return-address width, stack depth, log2(depth)
package ras_pkg;
  localparam int RAS_WIDTH = 32;
  localparam int RAS_DEPTH = 1024;
  localparam int RAS_ADDR  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPEC  = 2'd1,
    CLOSE = 2'd2
  } ras_ctrl_state_t;
endpackage

// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: bundles the fetch hint slot, branch resolution, prediction and
// ras strobe signals of ras_ctrl.
//   slave  : the sequencer side (ras_ctrl)
//   master : the environment side (fetch, resolution unit, ras)
interface ras_ctrl_if import ras_pkg::*; #(
  parameter int WIDTH = RAS_WIDTH
) ();
  logic             fe_valid;
  logic             fe_call;
  logic             fe_ret;
  logic             fe_branch;
  logic [WIDTH-1:0] fe_ret_addr;
  logic             fe_ready;
  logic             rs_valid;
  logic             rs_mispredict;
  logic             pred_valid;
  logic [WIDTH-1:0] pred_target;
  logic             pred_empty;
  logic             ovf;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_branch;
  logic             ras_close_valid;
  logic             ras_close_invalid;
  logic [WIDTH-1:0] ras_din;
  logic [WIDTH-1:0] ras_dout;

  modport slave (
    input  fe_valid, fe_call, fe_ret, fe_branch, fe_ret_addr,
    input  rs_valid, rs_mispredict, ras_dout,
    output fe_ready, pred_valid, pred_target, pred_empty, ovf,
    output ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid, ras_din
  );

  modport master (
    output fe_valid, fe_call, fe_ret, fe_branch, fe_ret_addr,
    output rs_valid, rs_mispredict, ras_dout,
    input  fe_ready, pred_valid, pred_target, pred_empty, ovf,
    input  ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid, ras_din
  );
endinterface

// File: rtl/ras_occ_cnt.sv
// ras_occ_cnt: saturating up/down occupancy counter with checkpoint load.
//   clk, rst_n : clock, async active-low reset
//   inc, dec   : push / pop happened this cycle (both together cancel)
//   load       : restore count from load_val (takes priority)
//   count      : current occupancy, 0..DEPTH
//   empty/full : count==0 / count==DEPTH
module ras_occ_cnt #(
  parameter int DEPTH = 1024,
  parameter int ADDR  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          load,
  input  logic [ADDR:0] load_val,
  output logic [ADDR:0] count,
  output logic          empty,
  output logic          full
);
  localparam logic [ADDR:0] CNT_ONE  = (ADDR+1)'(1);
  localparam logic [ADDR:0] CNT_FULL = (ADDR+1)'(DEPTH);

  logic [ADDR:0] count_q;
  logic [ADDR:0] count_d;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q >= CNT_FULL);

  // Next count: checkpoint restore wins, otherwise step once and never wrap.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && !dec && !full) begin
      count_d = count_q + CNT_ONE;
    end else if (dec && !inc && !empty) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: sequencer in front of the speculative return-address stack.
//   clk, rst_n : clock, async active-low reset (ras itself has no reset, so the
//                stack is treated as empty after reset)
//   bus        : ras_ctrl_if.slave -- fetch hint slot (fe_*), branch resolution
//                (rs_*), prediction (pred_*), sticky overflow (ovf) and the ras
//                strobes (ras_push/pop/branch/close_valid/close_invalid, din, dout)
// Only one speculative window is kept open; the occupancy is checkpointed when
// the window opens and restored when it closes on a mispredict.
module ras_ctrl import ras_pkg::*; #(
  parameter int DEPTH = RAS_DEPTH,
  parameter int ADDR  = RAS_ADDR
) (
  input  logic      clk,
  input  logic      rst_n,
  ras_ctrl_if.slave bus
);
  ras_ctrl_state_t state_q, state_d;
  logic [ADDR:0]   ckpt_q, ckpt_d;
  logic            mispredict_q, mispredict_d;
  logic            pred_valid_q, pred_valid_d;
  logic            pred_empty_q, pred_empty_d;
  logic            ovf_q, ovf_d;

  logic [ADDR:0]   count;
  logic            empty;
  logic            full;
  logic            fe_ready;
  logic            accept;
  logic            ras_push;
  logic            ras_pop;
  logic            close_valid;
  logic            close_invalid;
  logic            cnt_load;

  ras_occ_cnt #(.DEPTH(DEPTH), .ADDR(ADDR)) u_occ (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (ras_push),
    .dec     (ras_pop),
    .load    (cnt_load),
    .load_val(ckpt_q),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  // Slot acceptance: a second branch in SPEC or a resolution cycle stalls fetch.
  always_comb begin
    fe_ready = 1'b0;
    case (state_q)
      IDLE:    fe_ready = 1'b1;
      SPEC:    fe_ready = !bus.rs_valid && !bus.fe_branch;
      CLOSE:   fe_ready = 1'b0;
      default: fe_ready = 1'b0;
    endcase
  end

  assign accept   = bus.fe_valid && fe_ready;
  assign ras_push = accept && bus.fe_call && !full;
  assign ras_pop  = accept && bus.fe_ret && !empty;

  // Window FSM next state, checkpoint capture and close strobes.
  always_comb begin
    state_d       = state_q;
    ckpt_d        = ckpt_q;
    mispredict_d  = mispredict_q;
    close_valid   = 1'b0;
    close_invalid = 1'b0;
    cnt_load      = 1'b0;
    case (state_q)
      IDLE: begin
        // Checkpoint is the occupancy before any call/ret on the same slot.
        if (accept && bus.fe_branch) begin
          state_d = SPEC;
          ckpt_d  = count;
        end else begin
          state_d = IDLE;
        end
      end
      SPEC: begin
        if (bus.rs_valid) begin
          state_d      = CLOSE;
          mispredict_d = bus.rs_mispredict;
        end else begin
          state_d = SPEC;
        end
      end
      CLOSE: begin
        close_valid   = !mispredict_q;
        close_invalid = mispredict_q;
        cnt_load      = mispredict_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prediction flags and sticky overflow.
  always_comb begin
    pred_valid_d = accept && bus.fe_ret;
    pred_empty_d = accept && bus.fe_ret && empty;
    ovf_d        = ovf_q || (accept && bus.fe_call && full);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ckpt_q       <= '0;
      mispredict_q <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_empty_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ckpt_q       <= ckpt_d;
      mispredict_q <= mispredict_d;
      pred_valid_q <= pred_valid_d;
      pred_empty_q <= pred_empty_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.fe_ready          = fe_ready;
  assign bus.ras_push          = ras_push;
  assign bus.ras_pop           = ras_pop;
  assign bus.ras_branch        = accept && bus.fe_branch && (state_q == IDLE);
  assign bus.ras_close_valid   = close_valid;
  assign bus.ras_close_invalid = close_invalid;
  assign bus.ras_din           = ras_push ? bus.fe_ret_addr : '0;
  assign bus.pred_valid        = pred_valid_q;
  assign bus.pred_empty        = pred_empty_q;
  // An empty-stack prediction reports a zero target rather than stale ras data.
  assign bus.pred_target       = (pred_valid_q && !pred_empty_q) ? bus.ras_dout : '0;
  assign bus.ovf               = ovf_q;
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed bench for ras_ctrl. A small speculative ras stub sits
// next to the DUT (as in the real parent). Expected predictions are queued when
// a return is issued; a monitor pops and compares whenever pred_valid is high.
module tb_ras_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  ras_ctrl_if #(.WIDTH(32)) bus ();

  ras_ctrl #(.DEPTH(1024), .ADDR(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Ras stub: read latency 1, snapshot on branch, restore on close_invalid.
  logic [31:0] mem  [1024];
  logic [31:0] snap [1024];
  int          sp, snap_sp;
  logic [31:0] ras_dout_q;
  assign bus.ras_dout = ras_dout_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp         <= 0;
      snap_sp    <= 0;
      ras_dout_q <= 32'd0;
    end else if (bus.ras_close_invalid) begin
      mem <= snap;
      sp  <= snap_sp;
    end else begin
      if (bus.ras_branch) begin
        snap    <= mem;
        snap_sp <= sp;
      end
      if (bus.ras_push && bus.ras_pop) begin
        ras_dout_q  <= mem[sp-1];
        mem[sp-1]   <= bus.ras_din;
      end else if (bus.ras_push) begin
        mem[sp] <= bus.ras_din;
        sp      <= sp + 1;
      end else if (bus.ras_pop) begin
        ras_dout_q <= mem[sp-1];
        sp         <= sp - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Prediction monitor.
  always @(negedge clk) begin
    if (rst_n && bus.pred_valid) begin
      if (exp_q.size() == 0) begin
        chk("pred_unexpected", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("pred_empty", {31'd0, bus.pred_empty}, {31'd0, e[32]});
        chk("pred_target", bus.pred_target, e[31:0]);
      end
    end
  end

  task automatic expect_pred(input logic emp, input logic [31:0] tgt);
    exp_q.push_back({emp, tgt});
  endtask

  // One slot; exp = {fe_ready, ras_push, ras_pop, ras_branch, close_valid, close_invalid}.
  task automatic step(input logic v, input logic c, input logic r, input logic b,
                      input logic [31:0] a, input logic rv, input logic rm,
                      input logic [5:0] exp, input string name);
    @(negedge clk);
    bus.fe_valid      = v;
    bus.fe_call       = c;
    bus.fe_ret        = r;
    bus.fe_branch     = b;
    bus.fe_ret_addr   = a;
    bus.rs_valid      = rv;
    bus.rs_mispredict = rm;
    #1;
    chk(name, {26'd0, bus.fe_ready, bus.ras_push, bus.ras_pop, bus.ras_branch,
               bus.ras_close_valid, bus.ras_close_invalid}, {26'd0, exp});
    @(posedge clk);
  endtask

  task automatic idle(input string name);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b100000, name);
  endtask

  task automatic chk_count(input string name, input int n);
    #1;
    chk(name, 32'(dut.count), 32'(n));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {23'd0, bus.fe_ready, bus.ras_push, bus.ras_pop, bus.ras_branch,
               bus.ras_close_valid, bus.ras_close_invalid, bus.pred_valid,
               bus.pred_empty, bus.ovf}, {23'd0, 9'b100000000});
    chk({name, "_target"}, bus.pred_target, 32'd0);
    chk({name, "_din"}, bus.ras_din, 32'd0);
    chk({name, "_count"}, 32'(dut.count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.fe_valid = 1'b0; bus.fe_call = 1'b0; bus.fe_ret = 1'b0; bus.fe_branch = 1'b0;
    bus.fe_ret_addr = 32'd0; bus.rs_valid = 1'b0; bus.rs_mispredict = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Two calls then two returns: LIFO predictions.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 6'b110000, "call_a");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 6'b110000, "call_b");
    expect_pred(1'b0, 32'h200);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b101000, "ret_b");
    expect_pred(1'b0, 32'h100);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b101000, "ret_a");
    idle("idle_1");
    chk_count("count_after_rets", 0);

    // Return on an empty stack, and rs_valid in IDLE is ignored.
    expect_pred(1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b100000, "ret_empty");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 6'b100000, "rs_in_idle");
    idle("idle_2");
    chk_count("count_empty_ret", 0);

    // Fill to DEPTH, then one call too many.
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'(i), 1'b0, 1'b0, 6'b110000, "call_fill");
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hdead, 1'b0, 1'b0, 6'b100000, "call_full");
    #1;
    chk("ovf_set", {31'd0, bus.ovf}, 32'd1);
    chk_count("count_full", 1024);
    idle("idle_3");
    chk("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    do_reset();

    // Mispredict restores occupancy and the pre-branch top.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 6'b110000, "call_10");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 6'b110000, "call_20");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100100, "branch_open");
    expect_pred(1'b0, 32'h20);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b101000, "spec_ret_1");
    expect_pred(1'b0, 32'h10);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b101000, "spec_ret_2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 6'b110000, "spec_call");
    chk_count("count_spec", 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 6'b000000, "rs_mispredict");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000001, "close_invalid");
    chk_count("count_restored", 2);
    expect_pred(1'b0, 32'h20);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b101000, "ret_restored");

    // Second branch stalls until the window closes; then call+ret in one slot.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100100, "branch_2");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b000000, "branch_held");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 6'b000000, "branch_held_rs");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b000010, "close_valid");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100100, "branch_reopen");
    expect_pred(1'b0, 32'h10);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 6'b111000, "call_ret");
    chk_count("count_call_ret", 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 6'b000000, "rs_commit");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000010, "close_valid_2");

    // Call arriving with rs_valid is held through CLOSE and pushed in IDLE.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100100, "branch_3");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 1'b1, 1'b0, 6'b000000, "call_with_rs");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0, 6'b000010, "call_in_close");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0, 6'b110000, "call_in_idle");
    chk_count("count_after_held", 2);

    // Reset in the middle of a window.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100100, "branch_4");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 1'b0, 1'b0, 6'b110000, "call_600");
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100100, "branch_after_rst");
    expect_pred(1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b100000, "ret_after_rst");
    idle("idle_4");
    idle("idle_5");

    chk("pred_missing", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
